// File: rtl/sap_pkg.sv
// sap_pkg: shared types for the SuperAutoPets battle resolver.
//   species_t       3-bit species code (0..3 real pets, 4..7 empty)
//   PET_EMPTY       code published for empty or fainted slots
//   stats_t         packed {hp, atk} record
//   species_stats   constant base-stats lookup
//   battle_state_t  resolver FSM states
package sap_pkg;

    localparam int unsigned SPECIES_W = 3;
    localparam int unsigned STAT_W    = 4;
    localparam int unsigned STEPS_W   = 4;

    typedef logic [SPECIES_W-1:0] species_t;

    localparam species_t PET_EMPTY = 3'd4;

    typedef struct packed {
        logic [STAT_W-1:0] hp;
        logic [STAT_W-1:0] atk;
    } stats_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FIGHT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } battle_state_t;

    // Base stats per species; every code outside 0..3 is an empty slot.
    function automatic stats_t species_stats(input species_t code);
        stats_t s;
        case (code)
            3'd0:    s = '{hp: 4'd3, atk: 4'd2};
            3'd1:    s = '{hp: 4'd2, atk: 4'd3};
            3'd2:    s = '{hp: 4'd4, atk: 4'd1};
            3'd3:    s = '{hp: 4'd5, atk: 4'd2};
            default: s = '{hp: 4'd0, atk: 4'd0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/battle_slot.sv
// battle_slot: one fighter (player or opponent) in the battle resolver.
//   clk, reset   clock, async active-low reset
//   i_load       latch i_code and load hp from the stats table
//   i_code       species code to latch
//   i_dmg_en     subtract i_dmg from hp (saturating at 0)
//   i_dmg        incoming damage (attacker's atk)
//   i_faint      retire the slot if its hp has reached 0
//   o_status     species code while alive, PET_EMPTY otherwise
//   o_hp         current hit points
//   o_atk        attack of this fighter, 0 once dead or empty
module battle_slot
    import sap_pkg::*;
#(
    parameter int unsigned HP_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [2:0]          i_code,
    input  logic                i_dmg_en,
    input  logic [3:0]          i_dmg,
    input  logic                i_faint,
    output logic [2:0]          o_status,
    output logic [HP_W-1:0]     o_hp,
    output logic [3:0]          o_atk
);

    // Compare hp against damage at a width that holds both operands.
    localparam int unsigned CMP_W = (HP_W > STAT_W) ? HP_W : STAT_W;

    logic [2:0]      r_code;
    logic [HP_W-1:0] r_hp;
    logic            r_alive;
    logic [2:0]      r_status;

    logic            w_valid;
    logic [CMP_W-1:0] w_hp_ext;
    logic [CMP_W-1:0] w_dmg_ext;
    stats_t          w_load_stats;
    stats_t          w_cur_stats;

    assign w_valid      = (i_code[2] == 1'b0);
    assign w_load_stats = species_stats(i_code);
    assign w_cur_stats  = species_stats(r_code);
    assign w_hp_ext     = CMP_W'(r_hp);
    assign w_dmg_ext    = CMP_W'(i_dmg);

    // Load wins over damage; damage and faint never coincide in the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_code   <= PET_EMPTY;
            r_hp     <= '0;
            r_alive  <= 1'b0;
            r_status <= PET_EMPTY;
        end else if (i_load) begin
            r_code   <= i_code;
            r_hp     <= HP_W'(w_load_stats.hp);
            r_alive  <= w_valid;
            r_status <= w_valid ? i_code : PET_EMPTY;
        end else if (i_dmg_en) begin
            r_hp     <= (w_hp_ext > w_dmg_ext) ? HP_W'(w_hp_ext - w_dmg_ext) : '0;
        end else if (i_faint && (r_hp == '0)) begin
            r_alive  <= 1'b0;
            r_status <= PET_EMPTY;
        end
    end

    assign o_status = r_status;
    assign o_hp     = r_hp;
    assign o_atk    = r_alive ? w_cur_stats.atk : 4'd0;

endmodule

// File: rtl/battle_engine.sv
// battle_engine: sequential front-line battle resolver for SuperAutoPets.
// Optional feature: define SAP_BATTLE_TIMEOUT_EN to force a loss once
// `steps` reaches MAX_STEPS without a winner.
//   clk, reset                clock, async active-low reset
//   start                     pulse: begin a battle (IDLE/DONE only)
//   step                      pulse: one attack exchange (FIGHT only)
//   pet1, pet2, opp1, opp2    species codes, latched at start
//   pet1_status, pet2_status  species code while alive, 4 when fainted/empty
//   battle_done, battle_win   result flags (win valid while done)
//   busy                      high in LOAD, FIGHT and CHECK
//   steps                     attack ticks taken, saturating at 15
module battle_engine
    import sap_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 15,
    parameter int unsigned HP_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic [2:0] pet1,
    input  logic [2:0] pet2,
    input  logic [2:0] opp1,
    input  logic [2:0] opp2,
    output logic [2:0] pet1_status,
    output logic [2:0] pet2_status,
    output logic       battle_done,
    output logic       battle_win,
    output logic       busy,
    output logic [3:0] steps
);

    battle_state_t      r_state;
    logic               r_done;
    logic               r_win;
    logic               r_busy;
    logic [STEPS_W-1:0] r_steps;

    logic [2:0]      w_p1_status, w_p2_status, w_o1_status, w_o2_status;
    logic [HP_W-1:0] w_p1_hp, w_p2_hp, w_o1_hp, w_o2_hp;
    logic [3:0]      w_p1_atk, w_p2_atk, w_o1_atk, w_o2_atk;

    logic       w_load, w_hit, w_faint;
    logic       w_p1_alive, w_p2_alive, w_o1_alive, w_o2_alive;
    logic [3:0] w_p_front_atk, w_o_front_atk;
    logic       w_p1_dmg, w_p2_dmg, w_o1_dmg, w_o2_dmg;
    logic       w_p_any, w_o_any;
    logic       w_timeout;

    // Slot controls decoded from the registered state.
    assign w_load  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_hit   = step && (r_state == ST_FIGHT);
    assign w_faint = (r_state == ST_CHECK);

    // Front = first slot of each team whose status still shows a pet.
    assign w_p1_alive = (w_p1_status != PET_EMPTY);
    assign w_p2_alive = (w_p2_status != PET_EMPTY);
    assign w_o1_alive = (w_o1_status != PET_EMPTY);
    assign w_o2_alive = (w_o2_status != PET_EMPTY);

    assign w_p_front_atk = w_p1_alive ? w_p1_atk : w_p2_atk;
    assign w_o_front_atk = w_o1_alive ? w_o1_atk : w_o2_atk;

    assign w_p1_dmg = w_hit && w_p1_alive;
    assign w_p2_dmg = w_hit && !w_p1_alive && w_p2_alive;
    assign w_o1_dmg = w_hit && w_o1_alive;
    assign w_o2_dmg = w_hit && !w_o1_alive && w_o2_alive;

    // Survivors judged on post-exchange hp, before statuses are retired.
    assign w_p_any = (w_p1_hp != '0) || (w_p2_hp != '0);
    assign w_o_any = (w_o1_hp != '0) || (w_o2_hp != '0);

`ifdef SAP_BATTLE_TIMEOUT_EN
    assign w_timeout = (r_steps == STEPS_W'(MAX_STEPS));
`else
    // Constant false; the parameter reference folds away.
    assign w_timeout = 1'b0 && (MAX_STEPS == 0);
`endif

    battle_slot #(.HP_W(HP_W)) u_pet1 (
        .clk(clk), .reset(reset), .i_load(w_load), .i_code(pet1),
        .i_dmg_en(w_p1_dmg), .i_dmg(w_o_front_atk), .i_faint(w_faint),
        .o_status(w_p1_status), .o_hp(w_p1_hp), .o_atk(w_p1_atk)
    );

    battle_slot #(.HP_W(HP_W)) u_pet2 (
        .clk(clk), .reset(reset), .i_load(w_load), .i_code(pet2),
        .i_dmg_en(w_p2_dmg), .i_dmg(w_o_front_atk), .i_faint(w_faint),
        .o_status(w_p2_status), .o_hp(w_p2_hp), .o_atk(w_p2_atk)
    );

    battle_slot #(.HP_W(HP_W)) u_opp1 (
        .clk(clk), .reset(reset), .i_load(w_load), .i_code(opp1),
        .i_dmg_en(w_o1_dmg), .i_dmg(w_p_front_atk), .i_faint(w_faint),
        .o_status(w_o1_status), .o_hp(w_o1_hp), .o_atk(w_o1_atk)
    );

    battle_slot #(.HP_W(HP_W)) u_opp2 (
        .clk(clk), .reset(reset), .i_load(w_load), .i_code(opp2),
        .i_dmg_en(w_o2_dmg), .i_dmg(w_p_front_atk), .i_faint(w_faint),
        .o_status(w_o2_status), .o_hp(w_o2_hp), .o_atk(w_o2_atk)
    );

    // Resolver FSM with registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_win   <= 1'b0;
            r_busy  <= 1'b0;
            r_steps <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_done  <= 1'b0;
                        r_win   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_steps <= '0;
                    end
                end
                // Go straight to CHECK so empty teams resolve without a tick.
                ST_LOAD: begin
                    r_state <= ST_CHECK;
                end
                ST_FIGHT: begin
                    if (step) begin
                        r_state <= ST_CHECK;
                        if (r_steps != {STEPS_W{1'b1}}) begin
                            r_steps <= r_steps + STEPS_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (!w_o_any && w_p_any) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_win   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (!w_p_any || w_timeout) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_win   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_FIGHT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_win   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_steps <= '0;
                end
            endcase
        end
    end

    assign pet1_status = w_p1_status;
    assign pet2_status = w_p2_status;
    assign battle_done = r_done;
    assign battle_win  = r_win;
    assign busy        = r_busy;
    assign steps       = r_steps;

endmodule
